// File: rtl/hash_entry.sv
// hash_entry: PS/2 set-2 keyboard front end for the hash terminal.
// Filters and frames PS/2 scan codes, decodes hex digits and editing keys, and
// assembles the 1024-bit message block presented as inhash.
// Build option: define HASH_ENTRY_PARITY_EN to enable the odd-parity check.
module hash_entry #(
   parameter int unsigned FILTER_LEN     = 8,
   parameter int unsigned TIMEOUT_CYCLES = 100000
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          ps2_clk,
   input  logic          ps2_data,
   output logic [1023:0] inhash,
   output logic [8:0]    nibble_count,
   output logic          msg_valid,
   output logic          frame_err
);

   localparam int unsigned FiltW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
   localparam int unsigned ToW   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

   localparam logic [1:0] StIdle   = 2'd0;
   localparam logic [1:0] StData   = 2'd1;
   localparam logic [1:0] StParity = 2'd2;
   localparam logic [1:0] StStop   = 2'd3;

   logic             clk_s1, clk_s2;
   logic             data_s1, data_s2;
   logic             filt_q;
   logic [FiltW-1:0] filt_cnt_q;
   logic             fall;
   logic [1:0]       state_q;
   logic [2:0]       bit_cnt_q;
   logic [7:0]       shift_q;
   logic             par_q;
   logic [ToW-1:0]   to_cnt_q;
   logic             par_bad;
   logic             byte_rdy;
   logic [7:0]       byte_q;
   logic             brk_q, ext_q, done_q;
   logic             is_hex;
   logic [3:0]       nib;

   // Two-flop synchronizers for the asynchronous PS/2 lines (idle high).
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         clk_s1  <= 1'b1;
         clk_s2  <= 1'b1;
         data_s1 <= 1'b1;
         data_s2 <= 1'b1;
      end else begin
         clk_s1  <= ps2_clk;
         clk_s2  <= clk_s1;
         data_s1 <= ps2_data;
         data_s2 <= data_s1;
      end
   end

   // Glitch filter: flip the filtered clock after FILTER_LEN differing samples;
   // fall marks a filtered 1->0 change for exactly one cycle.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         filt_q     <= 1'b1;
         filt_cnt_q <= '0;
         fall       <= 1'b0;
      end else begin
         fall <= 1'b0;
         if (clk_s2 != filt_q) begin
            if (filt_cnt_q == FiltW'(FILTER_LEN - 1)) begin
               filt_q     <= clk_s2;
               filt_cnt_q <= '0;
               fall       <= filt_q;
            end else begin
               filt_cnt_q <= filt_cnt_q + FiltW'(1);
            end
         end else begin
            filt_cnt_q <= '0;
         end
      end
   end

`ifdef HASH_ENTRY_PARITY_EN
   // Odd parity: data bits plus parity bit must hold an odd number of ones.
   assign par_bad = ~(^{shift_q, par_q});
`else
   logic unused_par;
   assign unused_par = par_q;
   assign par_bad    = 1'b0;
`endif

   // Frame receiver: start, 8 data bits LSB first, parity, stop; a stalled
   // frame is abandoned silently after TIMEOUT_CYCLES without a fall.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         bit_cnt_q <= 3'd0;
         shift_q   <= 8'h00;
         par_q     <= 1'b0;
         to_cnt_q  <= '0;
         byte_rdy  <= 1'b0;
         byte_q    <= 8'h00;
         frame_err <= 1'b0;
      end else begin
         byte_rdy  <= 1'b0;
         frame_err <= 1'b0;
         if (fall) begin
            to_cnt_q <= '0;
            case (state_q)
               StIdle: begin
                  // A high bit here is not a start bit; ignore it.
                  if (!data_s2) begin
                     state_q   <= StData;
                     bit_cnt_q <= 3'd0;
                  end
               end
               StData: begin
                  shift_q   <= {data_s2, shift_q[7:1]};
                  bit_cnt_q <= bit_cnt_q + 3'd1;
                  if (bit_cnt_q == 3'd7) state_q <= StParity;
               end
               StParity: begin
                  par_q   <= data_s2;
                  state_q <= StStop;
               end
               StStop: begin
                  state_q <= StIdle;
                  if (!data_s2 || par_bad) begin
                     frame_err <= 1'b1;
                  end else begin
                     byte_rdy <= 1'b1;
                     byte_q   <= shift_q;
                  end
               end
               default: state_q <= StIdle;
            endcase
         end else if (state_q != StIdle) begin
            if (to_cnt_q == ToW'(TIMEOUT_CYCLES - 1)) begin
               state_q  <= StIdle;
               to_cnt_q <= '0;
            end else begin
               to_cnt_q <= to_cnt_q + ToW'(1);
            end
         end else begin
            to_cnt_q <= '0;
         end
      end
   end

   // Set-2 make code to hex nibble.
   always_comb begin
      is_hex = 1'b1;
      nib    = 4'h0;
      case (byte_q)
         8'h45: nib = 4'h0;
         8'h16: nib = 4'h1;
         8'h1E: nib = 4'h2;
         8'h26: nib = 4'h3;
         8'h25: nib = 4'h4;
         8'h2E: nib = 4'h5;
         8'h36: nib = 4'h6;
         8'h3D: nib = 4'h7;
         8'h3E: nib = 4'h8;
         8'h46: nib = 4'h9;
         8'h1C: nib = 4'hA;
         8'h32: nib = 4'hB;
         8'h21: nib = 4'hC;
         8'h23: nib = 4'hD;
         8'h24: nib = 4'hE;
         8'h2B: nib = 4'hF;
         default: is_hex = 1'b0;
      endcase
   end

   // Key decoder: break/extended prefixes, then one buffer action per byte.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         inhash       <= '0;
         nibble_count <= 9'd0;
         msg_valid    <= 1'b0;
         brk_q        <= 1'b0;
         ext_q        <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         msg_valid <= 1'b0;
         if (byte_rdy) begin
            if (brk_q) begin
               // Release code: swallow it and drop both prefixes.
               brk_q <= 1'b0;
               ext_q <= 1'b0;
            end else if (byte_q == 8'hF0) begin
               brk_q <= 1'b1;
            end else if (byte_q == 8'hE0) begin
               ext_q <= 1'b1;
            end else if (ext_q) begin
               // Only keypad Enter is honoured among extended keys.
               ext_q <= 1'b0;
               if (byte_q == 8'h5A) begin
                  msg_valid <= 1'b1;
                  done_q    <= 1'b1;
               end
            end else if (is_hex) begin
               if (done_q) begin
                  // First digit after Enter starts a new message.
                  done_q       <= 1'b0;
                  inhash       <= {1020'h0, nib};
                  nibble_count <= 9'd1;
               end else if (nibble_count != 9'd256) begin
                  inhash       <= {inhash[1019:0], nib};
                  nibble_count <= nibble_count + 9'd1;
               end
            end else begin
               case (byte_q)
                  8'h66: begin
                     done_q <= 1'b0;
                     if (nibble_count != 9'd0) begin
                        inhash       <= {4'h0, inhash[1023:4]};
                        nibble_count <= nibble_count - 9'd1;
                     end
                  end
                  8'h76: begin
                     inhash       <= '0;
                     nibble_count <= 9'd0;
                     done_q       <= 1'b0;
                  end
                  8'h5A: begin
                     msg_valid <= 1'b1;
                     done_q    <= 1'b1;
                  end
                  default: ;
               endcase
            end
         end
      end
   end

endmodule

// File: tb/tb_hash_entry.sv
// tb_hash_entry: directed table-driven bench for hash_entry.
// Frames are bit-banged on ps2_clk/ps2_data; outputs are sampled on negedges.
module tb_hash_entry;

   localparam int unsigned TO = 1000;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          ps2_clk;
   logic          ps2_data;
   logic [1023:0] inhash;
   logic [8:0]    nibble_count;
   logic          msg_valid;
   logic          frame_err;

   hash_entry #(
      .FILTER_LEN     (8),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .ps2_clk      (ps2_clk),
      .ps2_data     (ps2_data),
      .inhash       (inhash),
      .nibble_count (nibble_count),
      .msg_valid    (msg_valid),
      .frame_err    (frame_err)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Pulse monitor: counts strobe cycles and the fall-to-msg_valid distance.
   int cyc = 0;
   int fall_cyc = 0;
   int valid_total = 0;
   int err_total = 0;
   int last_lat = -1;
   always @(negedge clk) begin
      cyc++;
      if (dut.fall) fall_cyc = cyc;
      if (msg_valid) begin
         valid_total++;
         last_lat = cyc - fall_cyc;
      end
      if (frame_err) err_total++;
   end

   typedef struct {
      logic [7:0]  code;
      logic [63:0] hash;
      int          cnt;
      int          nvalid;
      int          nerr;
   } vec_t;

   vec_t tbl[26];

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_bits(input logic [10:0] bits, input int nbits);
      for (int i = 0; i < nbits; i++) begin
         wait_cyc(5);
         ps2_data = bits[i];
         wait_cyc(5);
         ps2_clk = 1'b0;
         wait_cyc(10);
         ps2_clk = 1'b1;
      end
   endtask

   task automatic send_frame(input logic [7:0] b, input bit flip_par, input bit bad_stop);
      logic [10:0] f;
      f = {~bad_stop, (~^b) ^ flip_par, b, 1'b0};
      send_bits(f, 11);
      wait_cyc(10);
      ps2_data = 1'b1;
   endtask

   task automatic chk_hash(input string name, input logic [1023:0] act,
                           input logic [1023:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got[63:0]=%h required[63:0]=%h", name, act[63:0], exp[63:0]);
      end
   endtask

   task automatic chk_int(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d required %0d", name, act, exp);
      end
   endtask

   initial begin
      int v0, e0;
      logic [1023:0] all_f;

      tbl[0]  = '{8'h16, 64'h1,   1, 0, 0};
      tbl[1]  = '{8'hF0, 64'h1,   1, 0, 0};
      tbl[2]  = '{8'h16, 64'h1,   1, 0, 0};
      tbl[3]  = '{8'h1C, 64'h1A,  2, 0, 0};
      tbl[4]  = '{8'hF0, 64'h1A,  2, 0, 0};
      tbl[5]  = '{8'h1C, 64'h1A,  2, 0, 0};
      tbl[6]  = '{8'h76, 64'h0,   0, 0, 0};
      tbl[7]  = '{8'h16, 64'h1,   1, 0, 0};
      tbl[8]  = '{8'h1E, 64'h12,  2, 0, 0};
      tbl[9]  = '{8'h26, 64'h123, 3, 0, 0};
      tbl[10] = '{8'h66, 64'h12,  2, 0, 0};
      tbl[11] = '{8'h76, 64'h0,   0, 0, 0};
      tbl[12] = '{8'h66, 64'h0,   0, 0, 0};
      tbl[13] = '{8'h24, 64'hE,   1, 0, 0};
      tbl[14] = '{8'h24, 64'hEE,  2, 0, 0};
      tbl[15] = '{8'h5A, 64'hEE,  2, 1, 0};
      tbl[16] = '{8'h45, 64'h0,   1, 0, 0};
      tbl[17] = '{8'hE0, 64'h0,   1, 0, 0};
      tbl[18] = '{8'h16, 64'h0,   1, 0, 0};
      tbl[19] = '{8'h16, 64'h1,   2, 0, 0};
      tbl[20] = '{8'hE0, 64'h1,   2, 0, 0};
      tbl[21] = '{8'h5A, 64'h1,   2, 1, 0};
      tbl[22] = '{8'h5A, 64'h1,   2, 1, 0};
      tbl[23] = '{8'h26, 64'h3,   1, 0, 0};
      tbl[24] = '{8'h12, 64'h3,   1, 0, 0};
      tbl[25] = '{8'h76, 64'h0,   0, 0, 0};

      rst_n    = 1'b0;
      ps2_clk  = 1'b1;
      ps2_data = 1'b1;
      wait_cyc(5);
      chk_hash("reset inhash", inhash, '0);
      chk_int("reset count", int'(nibble_count), 0);
      chk_int("reset msg_valid", int'(msg_valid), 0);
      chk_int("reset frame_err", int'(frame_err), 0);
      rst_n = 1'b1;
      wait_cyc(20);

      // Main key sequence.
      for (int i = 0; i < 26; i++) begin
         v0 = valid_total;
         e0 = err_total;
         last_lat = -1;
         send_frame(tbl[i].code, 1'b0, 1'b0);
         chk_hash($sformatf("vec%0d inhash", i), inhash, {960'h0, tbl[i].hash});
         chk_int($sformatf("vec%0d count", i), int'(nibble_count), tbl[i].cnt);
         chk_int($sformatf("vec%0d msg_valid cycles", i), valid_total - v0, tbl[i].nvalid);
         chk_int($sformatf("vec%0d frame_err cycles", i), err_total - e0, tbl[i].nerr);
         if (tbl[i].nvalid != 0)
            chk_int($sformatf("vec%0d msg_valid latency", i), last_lat, 2);
      end

      // Fill to 256 nibbles, then one more key must be ignored.
      all_f = '1;
      for (int i = 0; i < 256; i++) send_frame(8'h2B, 1'b0, 1'b0);
      chk_hash("full inhash", inhash, all_f);
      chk_int("full count", int'(nibble_count), 256);
      send_frame(8'h2B, 1'b0, 1'b0);
      chk_hash("overflow inhash", inhash, all_f);
      chk_int("overflow count", int'(nibble_count), 256);
      send_frame(8'h76, 1'b0, 1'b0);
      chk_int("esc after full", int'(nibble_count), 0);

      // Parity flip and bad stop bit.
      e0 = err_total;
      send_frame(8'h16, 1'b1, 1'b0);
`ifdef HASH_ENTRY_PARITY_EN
      chk_int("bad parity frame_err", err_total - e0, 1);
      chk_int("bad parity count", int'(nibble_count), 0);
`else
      chk_int("bad parity frame_err", err_total - e0, 0);
      chk_int("bad parity count", int'(nibble_count), 1);
`endif
      send_frame(8'h76, 1'b0, 1'b0);
      e0 = err_total;
      send_frame(8'h16, 1'b0, 1'b1);
      chk_int("bad stop frame_err", err_total - e0, 1);
      chk_int("bad stop count", int'(nibble_count), 0);

      // Stalled frame (start + 4 data bits) must time out silently.
      send_bits({1'b1, ~^8'h16, 8'h16, 1'b0}, 5);
      ps2_data = 1'b1;
      wait_cyc(TO + 200);
      e0 = err_total;
      send_frame(8'h16, 1'b0, 1'b0);
      chk_int("timeout count", int'(nibble_count), 1);
      chk_hash("timeout inhash", inhash, 1024'h1);
      chk_int("timeout frame_err", err_total - e0, 0);

      // Reset in the middle of a frame.
      send_frame(8'h1E, 1'b0, 1'b0);
      chk_int("pre-reset count", int'(nibble_count), 2);
      send_bits({1'b1, ~^8'h26, 8'h26, 1'b0}, 4);
      rst_n = 1'b0;
      wait_cyc(1);
      chk_hash("midreset inhash", inhash, '0);
      chk_int("midreset count", int'(nibble_count), 0);
      chk_int("midreset msg_valid", int'(msg_valid), 0);
      chk_int("midreset frame_err", int'(frame_err), 0);
      ps2_clk  = 1'b1;
      ps2_data = 1'b1;
      wait_cyc(20);
      rst_n = 1'b1;
      wait_cyc(20);
      e0 = err_total;
      send_frame(8'h16, 1'b0, 1'b0);
      chk_int("post-reset count", int'(nibble_count), 1);
      chk_hash("post-reset inhash", inhash, 1024'h1);
      chk_int("post-reset frame_err", err_total - e0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
